// File: rtl/up_down_wrap_monitor.sv
// up_down_wrap_monitor: checks each counter step, pulses on wraps/threshold, saturating wrap count, sticky fault.
// Optional WRAP_MON_DIRCHG_EN adds a saturating direction-change counter dir_chg_cnt.
module up_down_wrap_monitor #(
  parameter int N = 4,
  parameter int WCNT_W = 8,
  parameter logic [N-1:0] THRESH = N'(8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl,
  input  logic [N-1:0]      q,
  input  logic              clr,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              thr_hit,
  output logic              step_err,
  output logic              fault,
  output logic [WCNT_W-1:0] wrap_cnt
`ifdef WRAP_MON_DIRCHG_EN
  ,
  output logic [WCNT_W-1:0] dir_chg_cnt
`endif
);
  typedef enum logic [1:0] {S_INIT, S_TRACK, S_FAULT} state_t;
  state_t state;
  logic [N-1:0] q_d, exp_q;
  logic ctrl_d, trk, ok, wu, wd;
  always_comb begin
    exp_q = ctrl_d ? q_d - 1'b1 : q_d + 1'b1;
    trk = state == S_TRACK;
    ok = q == exp_q;
    wu = trk & ok & ~ctrl_d & (&q_d) & ~|q;
    wd = trk & ok & ctrl_d & ~|q_d & (&q);
  end
  assign fault = state == S_FAULT;
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state <= S_INIT;
      q_d <= '0;
      ctrl_d <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      thr_hit <= 1'b0;
      step_err <= 1'b0;
      wrap_cnt <= '0;
`ifdef WRAP_MON_DIRCHG_EN
      dir_chg_cnt <= '0;
`endif
    end else begin
      q_d <= q;
      ctrl_d <= ctrl;
      wrap_up <= wu;
      wrap_dn <= wd;
      thr_hit <= trk & ok & (q == THRESH);
      step_err <= trk & ~ok;
      if ((wu | wd) && !(&wrap_cnt)) wrap_cnt <= wrap_cnt + 1'b1;
`ifdef WRAP_MON_DIRCHG_EN
      if (trk && ctrl != ctrl_d && !(&dir_chg_cnt)) dir_chg_cnt <= dir_chg_cnt + 1'b1;
`endif
      state <= state == S_INIT ? S_TRACK : (trk & ~ok) ? S_FAULT : state;
    end
  end
endmodule
